// File: rtl/sprite_blitter_rmw.sv
// Sprite blitter: read-modify-write merge of ROM sprite pixels into a 16-bit SRAM frame buffer,
// plus next-frame clear with display buffer swap.
module sprite_blitter_rmw #(
   parameter int PIXEL_BITS  = 4,
   parameter int SPRITE_SIZE = 16,
   parameter int SHEET_COLS  = 16,
   parameter int SHEET_ROWS  = 8,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int TRANSPARENT = 0,
   parameter int CLEAR_COLOR = 1,
   parameter int SRAM_WAIT   = 2
) (
   input  logic                          Clk,
   input  logic                          Reset_N,
   input  logic                          EN,
   input  logic [$clog2(SHEET_COLS)-1:0] spritesheetX,
   input  logic [$clog2(SHEET_ROWS)-1:0] spritesheetY,
   input  logic [9:0]                    imgX,
   input  logic [9:0]                    imgY,
   input  logic                          hflip,
   input  logic                          vflip,
   input  logic                          draw_start,
   input  logic                          clear_start,
   output logic                          done,
   output logic                          step_done,
   output logic                          even_frame,
   output logic [$clog2(SHEET_ROWS*SHEET_COLS*SPRITE_SIZE*SPRITE_SIZE)-1:0] rom_address,
   input  logic [PIXEL_BITS-1:0]         rom_data,
   output logic [15:0]                   Data_to_SRAM,
   input  logic [15:0]                   Data_from_SRAM,
   output logic                          SRAM_WE_N,
   output logic                          SRAM_OE_N,
   output logic [19:0]                   SRAM_ADDRESS
);
   localparam int PPW = 16 / PIXEL_BITS;
   localparam int PW  = $clog2(PPW);
   localparam int SW  = $clog2(SPRITE_SIZE);
   localparam int CW  = $clog2(SHEET_COLS);
   localparam int RW  = $clog2(SHEET_ROWS);
   localparam int WW  = $clog2(SRAM_WAIT + 2);
   localparam logic [10:0]           LAST_WORD = 11'((SCREEN_W - 1) / PPW);
   localparam logic [PIXEL_BITS-1:0] TR_PX     = PIXEL_BITS'(TRANSPARENT);
   localparam logic [PIXEL_BITS-1:0] CLR_PX    = PIXEL_BITS'(CLEAR_COLOR);
   localparam logic [WW-1:0]         RD_LAST   = WW'(SRAM_WAIT);
   localparam logic [WW-1:0]         WR_LAST   = WW'(SRAM_WAIT + 1);
   localparam logic [SW-1:0]         SS_LAST   = SW'(SPRITE_SIZE - 1);

   typedef enum logic [2:0] {IDLE, ROW_START, RD, MERGE, WR, CLR_WR, CLR_ROW_END, DONE} state_t;

   function automatic logic [15:0] fill_word(input logic [PIXEL_BITS-1:0] px);
      logic [15:0] w;
      w = 16'h0000;
      for (int i = 0; i < PPW; i++) w[i*PIXEL_BITS +: PIXEL_BITS] = px;
      return w;
   endfunction

   state_t          state_r, state_s;
   logic            even_frame_r, frame_r, hflip_r, vflip_r, phase_r;
   logic [9:0]      y_r, img_x_r, img_y_r;
   logic [7:0]      word_r;
   logic [SW-1:0]   sy_r, row_off_s, rom_col_s;
   logic [PW-1:0]   p_r;
   logic [WW-1:0]   wait_r;
   logic [15:0]     wbuf_r, clr_word_s;
   logic [CW-1:0]   col_r;
   logic [RW-1:0]   row_r;
   logic [10:0]     scr_row_s, first_word_s, end_word_s, last_word_s;
   logic [11:0]     pix_x_s, sx_s;
   logic            row_skip_s, sx_ok_s, row_done_s, sy_last_s;

   assign clr_word_s = fill_word(CLR_PX);

   // Screen row/word bounds for the current sprite row and sprite column of the current pixel.
   always_comb begin
      row_off_s    = vflip_r ? (SS_LAST - sy_r) : sy_r;
      scr_row_s    = {1'b0, img_y_r} + 11'(row_off_s);
      first_word_s = {1'b0, img_x_r} >> PW;
      end_word_s   = ({1'b0, img_x_r} + 11'(SPRITE_SIZE - 1)) >> PW;
      last_word_s  = (end_word_s > LAST_WORD) ? LAST_WORD : end_word_s;
      row_skip_s   = (scr_row_s >= 11'(SCREEN_H)) || (first_word_s > LAST_WORD);
      pix_x_s      = 12'({word_r, p_r});
      sx_s         = pix_x_s - {2'b00, img_x_r};
      sx_ok_s      = !sx_s[11] && (sx_s < 12'(SPRITE_SIZE)) && (pix_x_s < 12'(SCREEN_W));
      rom_col_s    = hflip_r ? (SS_LAST - sx_s[SW-1:0]) : sx_s[SW-1:0];
      row_done_s   = ({3'b000, word_r} == last_word_s);
      sy_last_s    = (sy_r == SS_LAST);
   end

   // Next-state logic; only DONE->IDLE may proceed without the grant.
   always_comb begin
      state_s = state_r;
      if (EN) begin
         case (state_r)
            IDLE:        if (clear_start) state_s = CLR_WR;
                         else if (draw_start) state_s = ROW_START;
                         else state_s = IDLE;
            ROW_START:   if (!row_skip_s) state_s = RD;
                         else if (sy_last_s) state_s = DONE;
                         else state_s = ROW_START;
            RD:          state_s = (wait_r == RD_LAST) ? MERGE : RD;
            MERGE:       state_s = (phase_r && (p_r == PW'(PPW - 1))) ? WR : MERGE;
            WR:          if (wait_r != WR_LAST) state_s = WR;
                         else if (!row_done_s) state_s = RD;
                         else if (sy_last_s) state_s = DONE;
                         else state_s = ROW_START;
            CLR_WR:      state_s = ({3'b000, word_r} == LAST_WORD) ? CLR_ROW_END : CLR_WR;
            CLR_ROW_END: state_s = (y_r == 10'(SCREEN_H - 1)) ? DONE : CLR_WR;
            DONE:        state_s = (!draw_start && !clear_start) ? IDLE : DONE;
            default:     state_s = IDLE;
         endcase
      end else if (state_r == DONE && !draw_start && !clear_start) begin
         state_s = IDLE;
      end else begin
         state_s = state_r;
      end
   end

   // State register.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) state_r <= IDLE;
      else          state_r <= state_s;
   end

   // Datapath: command latching, counters and the merge buffer; everything holds while EN=0.
   always_ff @(posedge Clk or negedge Reset_N) begin
      if (!Reset_N) begin
         even_frame_r <= 1'b0;  frame_r <= 1'b0;  hflip_r <= 1'b0;  vflip_r <= 1'b0;
         phase_r      <= 1'b0;  y_r     <= 10'd0; img_x_r <= 10'd0; img_y_r <= 10'd0;
         word_r       <= 8'd0;  sy_r    <= '0;    p_r     <= '0;    wait_r  <= '0;
         wbuf_r       <= 16'h0000; col_r <= '0;   row_r   <= '0;
      end else if (EN) begin
         case (state_r)
            IDLE: begin
               if (clear_start) begin
                  even_frame_r <= ~even_frame_r;
                  frame_r      <= even_frame_r;
                  y_r          <= 10'd0;
                  word_r       <= 8'd0;
               end else if (draw_start) begin
                  frame_r <= ~even_frame_r;
                  img_x_r <= imgX;          img_y_r <= imgY;
                  col_r   <= spritesheetX;  row_r   <= spritesheetY;
                  hflip_r <= hflip;         vflip_r <= vflip;
                  sy_r    <= '0;
               end
            end
            ROW_START: begin
               if (row_skip_s) begin
                  sy_r <= sy_r + SW'(1);
               end else begin
                  y_r    <= scr_row_s[9:0];
                  word_r <= first_word_s[7:0];
                  wait_r <= '0;
               end
            end
            RD: begin
               if (wait_r == RD_LAST) begin
                  wbuf_r  <= Data_from_SRAM;
                  wait_r  <= '0;
                  p_r     <= '0;
                  phase_r <= 1'b0;
               end else begin
                  wait_r <= wait_r + WW'(1);
               end
            end
            MERGE: begin
               phase_r <= ~phase_r;
               if (phase_r) begin
                  if (sx_ok_s && rom_data != TR_PX) wbuf_r[p_r*PIXEL_BITS +: PIXEL_BITS] <= rom_data;
                  p_r <= p_r + PW'(1);
               end
            end
            WR: begin
               if (wait_r == WR_LAST) begin
                  wait_r <= '0;
                  if (row_done_s) sy_r <= sy_r + SW'(1);
                  else            word_r <= word_r + 8'd1;
               end else begin
                  wait_r <= wait_r + WW'(1);
               end
            end
            CLR_WR:      word_r <= ({3'b000, word_r} == LAST_WORD) ? 8'd0 : word_r + 8'd1;
            CLR_ROW_END: y_r <= y_r + 10'd1;
            default: ;
         endcase
      end
   end

   assign done         = (state_r == DONE);
   assign step_done    = (state_r == IDLE) || (state_r == DONE) || (state_r == CLR_ROW_END);
   assign even_frame   = even_frame_r;
   assign rom_address  = {row_r, col_r, sy_r, rom_col_s};
   assign SRAM_ADDRESS = {1'b0, frame_r, y_r, word_r};
   assign SRAM_OE_N    = !(EN && state_r == RD);
   assign SRAM_WE_N    = !(EN && ((state_r == WR && wait_r <= RD_LAST) || state_r == CLR_WR));
   assign Data_to_SRAM = (EN && state_r == CLR_WR) ? clr_word_s :
                         (EN && state_r == WR)     ? wbuf_r     : 16'hzzzz;
endmodule

// File: tb/tb_sprite_blitter_rmw.sv
// Randomised bench for sprite_blitter_rmw on a reduced 160x120 screen, checked against a
// pixel-level frame buffer model.
module tb_sprite_blitter_rmw;
   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int WORDS    = SCREEN_W / 4;
   localparam int SS       = 16;

   logic        clk = 1'b0;
   logic        rst_n, en, hflip, vflip, draw_start, clear_start;
   logic [3:0]  sheet_x;
   logic [2:0]  sheet_y;
   logic [9:0]  img_x, img_y;
   logic        done, step_done, even_frame, we_n, oe_n;
   logic [14:0] rom_address;
   logic [3:0]  rom_data;
   wire  [15:0] data_to_sram;
   logic [15:0] data_from_sram;
   logic [19:0] sram_address;

   logic [15:0] mem     [0:524287];
   logic [15:0] exp_mem [0:524287];
   logic [3:0]  rom     [0:32767];
   bit          wr_seen [int];
   int          checks = 0, errors = 0, exp_words = 0, last_wr_count = 0;
   bit          finished = 1'b0, even_m = 1'b0, cur_frame = 1'b0;

   always #5 clk = ~clk;

   sprite_blitter_rmw #(
      .PIXEL_BITS(4), .SPRITE_SIZE(16), .SHEET_COLS(16), .SHEET_ROWS(8),
      .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .TRANSPARENT(0), .CLEAR_COLOR(1), .SRAM_WAIT(2)
   ) dut (
      .Clk(clk), .Reset_N(rst_n), .EN(en), .spritesheetX(sheet_x), .spritesheetY(sheet_y),
      .imgX(img_x), .imgY(img_y), .hflip(hflip), .vflip(vflip),
      .draw_start(draw_start), .clear_start(clear_start),
      .done(done), .step_done(step_done), .even_frame(even_frame),
      .rom_address(rom_address), .rom_data(rom_data),
      .Data_to_SRAM(data_to_sram), .Data_from_SRAM(data_from_sram),
      .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_ADDRESS(sram_address)
   );

   assign data_from_sram = mem[sram_address[18:0]];

   // Spritesheet ROM with one cycle latency and the SRAM write port.
   always @(posedge clk) begin
      rom_data <= rom[rom_address];
      if (rst_n === 1'b1 && we_n === 1'b0) mem[sram_address[18:0]] <= data_to_sram;
   end

   function automatic int idx(input int f, input int y, input int w);
      return f * 262144 + y * 256 + w;
   endfunction

   task automatic report();
      if (!finished) begin
         finished = 1'b1;
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
         if (errors >= 40) report();
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Per-cycle bus checks: strobe gating, address bounds and write data against the model.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         if (!en) check("en_gate", {30'd0, we_n, oe_n}, 32'd3);
         if (!we_n || !oe_n) begin
            check("dual_strobe", {31'd0, we_n | oe_n}, 32'd1);
            check("addr_range", {31'd0, sram_address[19] == 1'b0 && sram_address[18] == cur_frame &&
                  int'(sram_address[17:8]) < SCREEN_H && int'(sram_address[7:0]) < WORDS}, 32'd1);
         end
         if (!we_n) begin
            check("wr_data", 32'(data_to_sram), 32'(exp_mem[sram_address[18:0]]));
            wr_seen[int'(sram_address)] = 1'b1;
         end
      end
   end

   task automatic model_clear();
      even_m    = ~even_m;
      cur_frame = ~even_m;
      for (int y = 0; y < SCREEN_H; y++)
         for (int w = 0; w < WORDS; w++) exp_mem[idx(cur_frame, y, w)] = 16'h1111;
      exp_words = SCREEN_H * WORDS;
   endtask

   task automatic model_draw(input int col, input int row, input int ix, input int iy,
                             input bit hf, input bit vf);
      bit touched [int];
      int ys, xs, v, a;
      cur_frame = ~even_m;
      sheet_x = 4'(col); sheet_y = 3'(row); img_x = 10'(ix); img_y = 10'(iy);
      hflip = hf; vflip = vf;
      for (int r = 0; r < SS; r++) begin
         for (int c = 0; c < SS; c++) begin
            ys = iy + (vf ? SS - 1 - r : r);
            xs = ix + c;
            if (ys < SCREEN_H && xs < SCREEN_W) begin
               a = idx(cur_frame, ys, xs / 4);
               touched[a] = 1'b1;
               v = int'(rom[row * 4096 + col * 256 + r * 16 + (hf ? SS - 1 - c : c)]);
               if (v != 0) exp_mem[a][(xs % 4) * 4 +: 4] = 4'(v);
            end
         end
      end
      exp_words = touched.num();
   endtask

   task automatic frame_compare();
      int mism = 0;
      for (int f = 0; f < 2; f++)
         for (int y = 0; y < SCREEN_H; y++)
            for (int w = 0; w < WORDS; w++)
               if (mem[idx(f, y, w)] !== exp_mem[idx(f, y, w)]) mism++;
      check("frame_cmp", mism, 0);
   endtask

   // mode 0: EN held high; 1: random EN; 2: 20-cycle grant drops in IDLE and mid-write.
   task automatic run_cmd(input bit is_clear, input int mode);
      int n;
      wr_seen.delete();
      if (is_clear) clear_start = 1'b1;
      else          draw_start  = 1'b1;
      if (mode == 2) begin
         en = 1'b0;
         for (int i = 0; i < 20; i++) begin
            tick(1);
            check("idle_hold", {30'd0, done, step_done}, 32'd1);
         end
         en = 1'b1;
         n = 0;
         while (we_n && n < 5000) begin tick(1); n++; end
         check("reach_wr", {31'd0, we_n}, 32'd0);
         en = 1'b0;
         tick(20);
         en = 1'b1;
      end
      n = 0;
      while (!done && n < 20000) begin
         if (mode == 1) en = ($urandom_range(3) != 0);
         tick(1);
         n++;
      end
      en = 1'b1;
      check("done_seen", {31'd0, done}, 32'd1);
      check("step_done_in_done", {31'd0, step_done}, 32'd1);
      last_wr_count = wr_seen.num();
      check("word_count", last_wr_count, exp_words);
      check("even_frame", {31'd0, even_frame}, {31'd0, even_m});
      draw_start = 1'b0; clear_start = 1'b0; en = 1'b0;
      tick(1);
      check("done_drop", {30'd0, done, step_done}, 32'd1);
      en = 1'b1;
      tick(1);
      frame_compare();
   endtask

   initial begin
      rst_n = 1'b0; en = 1'b1; draw_start = 1'b0; clear_start = 1'b0;
      sheet_x = 4'd0; sheet_y = 3'd0; img_x = 10'd0; img_y = 10'd0; hflip = 1'b0; vflip = 1'b0;
      for (int i = 0; i < 524288; i++) begin mem[i] = 16'($urandom); exp_mem[i] = mem[i]; end
      for (int i = 0; i < 32768; i++) rom[i] = ($urandom_range(3) == 0) ? 4'h0 : 4'($urandom_range(15));
      for (int r = 0; r < SS; r++)
         for (int c = 0; c < SS; c++) rom[r * 16 + c] = 4'((c - r) & 15);
      tick(3);
      check("rst_even", {31'd0, even_frame}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_strobes", {30'd0, we_n, oe_n}, 32'd3);
      check("rst_step", {31'd0, step_done}, 32'd1);
      rst_n = 1'b1;
      tick(2);

      // Reset in the middle of a clear.
      model_clear();
      clear_start = 1'b1;
      tick(300);
      rst_n = 1'b0;
      #1;
      check("midrst_even", {31'd0, even_frame}, 32'd0);
      check("midrst_done", {31'd0, done}, 32'd0);
      check("midrst_strobes", {30'd0, we_n, oe_n}, 32'd3);
      even_m = 1'b0;
      clear_start = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);

      model_clear();
      run_cmd(1'b1, 0);
      check("t1_even", {31'd0, even_frame}, 32'd1);
      check("t1_first", 32'(mem[idx(0, 0, 0)]), 32'h1111);
      check("t1_last", 32'(mem[idx(0, SCREEN_H - 1, WORDS - 1)]), 32'h1111);

      model_draw(0, 0, 8, 4, 1'b0, 1'b0);
      run_cmd(1'b0, 0);
      check("t2_r4w2", 32'(mem[idx(0, 4, 2)]), 32'h3211);
      check("t2_r4w5", 32'(mem[idx(0, 4, 5)]), 32'hFEDC);
      check("t2_r5w2", 32'(mem[idx(0, 5, 2)]), 32'h211F);
      check("t2_r4w1", 32'(mem[idx(0, 4, 1)]), 32'h1111);
      check("t2_r4w6", 32'(mem[idx(0, 4, 6)]), 32'h1111);
      check("t2_words", last_wr_count, 64);

      model_clear();
      run_cmd(1'b1, 0);
      model_draw(0, 0, 5, 4, 1'b0, 1'b0);
      run_cmd(1'b0, 0);
      check("t3_r4w1", 32'(mem[idx(1, 4, 1)]), 32'h2111);
      check("t3_r4w5", 32'(mem[idx(1, 4, 5)]), 32'h111F);
      check("t3_words", last_wr_count, 80);

      model_clear();
      run_cmd(1'b1, 0);
      model_draw(0, 0, 0, 0, 1'b1, 1'b0);
      run_cmd(1'b0, 0);
      check("t4_r0w0", 32'(mem[idx(0, 0, 0)]), 32'hCDEF);
      check("t4_r0w3", 32'(mem[idx(0, 0, 3)]), 32'h1123);

      model_draw(0, 0, 156, 110, 1'b0, 1'b0);
      run_cmd(1'b0, 0);
      check("t5_r110w39", 32'(mem[idx(0, 110, 39)]), 32'h3211);
      check("t5_words", last_wr_count, 10);

      model_draw(1, 1, 1020, 1015, 1'b0, 1'b0);
      run_cmd(1'b0, 0);
      check("offscreen_words", last_wr_count, 0);

      model_draw(0, 0, 20, 30, 1'b0, 1'b1);
      run_cmd(1'b0, 0);
      check("vflip_r30w5", 32'(mem[idx(0, 30, 5)]), 32'h4321);
      check("vflip_r45w5", 32'(mem[idx(0, 45, 5)]), 32'h3211);

      model_draw(2, 3, 37, 50, 1'b1, 1'b1);
      run_cmd(1'b0, 2);

      for (int k = 0; k < 8; k++) begin
         if (k == 4) begin
            model_clear();
            run_cmd(1'b1, 1);
         end
         model_draw($urandom_range(15), $urandom_range(7), $urandom_range(175), $urandom_range(130),
                    1'($urandom_range(1)), 1'($urandom_range(1)));
         run_cmd(1'b0, 1);
      end
      report();
   end
endmodule

// File: doc/sprite_blitter_rmw.md
Name: sprite_blitter_rmw

Overview:
- Parametrised successor to the 4-bit sprite draw/clear engine.
- Copies one SPRITE_SIZE x SPRITE_SIZE sprite from an external spritesheet ROM into the next-frame buffer in SRAM, with pixel-accurate X placement, optional H/V flip, right/bottom screen clipping and a configurable transparent colour.
- Clears the next-frame buffer and swaps frame buffers on command.
- Sits behind the graphics accelerator arbiter, which may pause it wherever step_done=1.

Parameters:
- PIXEL_BITS, 4, bits per pixel; legal values 2, 4, 8. PPW = 16/PIXEL_BITS pixels per SRAM word.
- SPRITE_SIZE, 16, sprite width/height in pixels; power of 2, >= PPW.
- SHEET_COLS, 16, sprites per spritesheet row.
- SHEET_ROWS, 8, sprite rows in the spritesheet.
- SCREEN_W, 640, visible width in pixels; must be <= 256*PPW.
- SCREEN_H, 480, visible height in pixels; must be <= 1024.
- TRANSPARENT, 0, pixel value that is never written.
- CLEAR_COLOR, 1, pixel value replicated PPW times on clear.
- SRAM_WAIT, 2, extra cycles OE_N/WE_N are held before data is latched or WE_N is released.

Ports:
- Clk  in  1  clock.
- Reset_N  in  1  asynchronous, active-low reset.
- EN  in  1  arbiter grant; advance only when 1.
- spritesheetX  in  clog2(SHEET_COLS)  sprite column.
- spritesheetY  in  clog2(SHEET_ROWS)  sprite row.
- imgX, imgY  in  10 each  top-left screen pixel, unsigned.
- hflip, vflip  in  1 each  mirror sprite; latched at start.
- draw_start, clear_start  in  1 each  level commands.
- done  out  1  command complete.
- step_done  out  1  safe pause point.
- even_frame  out  1  current display buffer select.
- rom_address  out  clog2(SHEET_ROWS*SHEET_COLS*SPRITE_SIZE^2)  layout {row, col, sy, sx}.
- rom_data  in  PIXEL_BITS  valid 1 cycle after rom_address.
- Data_to_SRAM  out  16  write data; Z when not writing.
- Data_from_SRAM  in  16  read data.
- SRAM_WE_N, SRAM_OE_N  out  1 each  active-low strobes.
- SRAM_ADDRESS  out  20  {1'b0, frame, y[9:0], word[7:0]}. Pixel p of a word occupies bits [p*PIXEL_BITS +: PIXEL_BITS].

Behaviour:
- Reset values: state IDLE, even_frame 0, done 0, SRAM_WE_N 1, SRAM_OE_N 1, Data_to_SRAM Z, all counters 0.
- step_done=1 only in IDLE, DONE and CLR_ROW_END.
- EN=0: all registers hold, except DONE may return to IDLE.
- EN=0 outside a step_done state: state is frozen, WE_N and OE_N are forced 1, Data_to_SRAM is Z.
- IDLE:
  - clear_start has priority over draw_start.
  - clear_start -> toggle even_frame, set frame=new ~even_frame, y=0, word=0, go to CLR_WR.
  - draw_start -> latch all inputs, sy=0, go to ROW_START.
- ROW_START:
  - Screen row = imgY + (vflip ? SPRITE_SIZE-1-sy : sy).
  - If the row is >= SCREEN_H, skip the row.
  - Otherwise word runs from imgX/PPW to min((imgX+SPRITE_SIZE-1)/PPW, (SCREEN_W-1)/PPW).
  - This is SPRITE_SIZE/PPW words when imgX%PPW==0, else SPRITE_SIZE/PPW+1.
- RD:
  - OE_N=0 for 1+SRAM_WAIT cycles; Data_from_SRAM is latched on the last of these cycles into wbuf.
- MERGE, p = 0..PPW-1, 2 cycles per pixel (address, then data):
  - sx = word*PPW + p - imgX.
  - If 0 <= sx < SPRITE_SIZE, the screen x is < SCREEN_W, and rom_data != TRANSPARENT, replace pixel p of wbuf with rom_data.
  - ROM column = hflip ? SPRITE_SIZE-1-sx : sx.
  - Out-of-range pixels keep the read value.
- WR:
  - WE_N=0 with Data_to_SRAM=wbuf for 1+SRAM_WAIT cycles.
  - Then 1 cycle WE_N=1 with data still driven.
  - Then next word; after the last word of a row, next sy.
  - After sy=SPRITE_SIZE-1 -> DONE.
- CLR_WR:
  - WE_N=0, data = CLEAR_COLOR replicated; word increments each cycle.
  - At word=(SCREEN_W-1)/PPW -> CLR_ROW_END, where WE_N=1, then y++.
  - At y=SCREEN_H -> DONE.
- DONE: done=1; go to IDLE when draw_start=0 and clear_start=0, regardless of EN.
- Reset_N asserted mid-operation: immediate return to reset values. A partial SRAM write is acceptable. even_frame returns to 0.
- Arithmetic:
  - Screen x/y sums use 11 bits, so there is no wrap past 1023.
  - Any pixel whose sum is >= SCREEN_W/H is clipped.

Test Plan:
1. Reset, clear_start=1, EN=1 -> even_frame=1. Every word of frame 0 rows 0..479, words 0..159 reads 16'h1111. done=1 until clear_start drops. Frame 1 is untouched.
2. Sprite (0,0) with a diagonal pattern, imgX=8, imgY=4, draw_start -> exactly 4 words per row are written at rows 4..19, words 2..5. Transparent pixels keep the prior 16'h1111.
3. Same sprite at imgX=5 -> 5 words per row, words 1..5. Word 1 keeps pixel 0, pixels 1..3 take sx 0..2. Word 5 takes sx 15 in pixel 0, pixels 1..3 are unchanged.
4. hflip=1, imgX=0, sprite row 0 = 0..F -> screen row pixels read F,E,...,1, and screen pixel 15 keeps the old value (transparent 0).
5. imgX=636, imgY=470 -> only word 159 written per row, rows 470..479 only. No SRAM access with y >= 480 or word >= 160.
6. Drop EN for 20 cycles during draw, once in IDLE and once mid-WR -> SRAM contents after completion are identical to an uninterrupted run; WE_N stays 1 while EN=0.
